card_pair_controller: RTL and testbench
=======================================

# card_pair_controller

Game-logic stage for the 4×4 memory board, sitting between the mouse controller and the card renderer. It turns left-button presses into card selections and tracks which cards are face up and which are matched. It compares each pair, holds mismatched pairs visible for a fixed time, then hides them, and flags game completion. Outputs feed `draw_cards` as per-card bitmaps; `draw_cards` is enabled by the game state machine.

## Interface
Parameters:
- `GRID_X`, 192: x of the left edge of column 0 (pixels).
- `GRID_Y`, 64: y of the top edge of row 0 (pixels).
- `CARD_W`, 128: card width (pixels).
- `CARD_H`, 128: card height (pixels).
- `GAP`, 32: spacing between adjacent cards, both axes (pixels).
- `SHOW_CYCLES`, 65_000_000: clk cycles a mismatched pair stays visible (1 s at 65 MHz); counter 27 bits.

Ports:
- `clk` in 1: pixel/system clock (65 MHz).
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: game enable, a level signal from the state machine (`draw_cards`).
- `xpos` in 12: mouse x (delay-aligned).
- `ypos` in 12: mouse y.
- `left` in 1: left-button level from the mouse controller.
- `card_values` in 64: pair ID of card i at bits [4i+3:4i]; each ID 0–7 appears exactly twice.
- `face_up` out 16: bit i = card i currently shown, not yet matched.
- `matched` out 16: bit i = card i permanently matched.
- `pairs_found` out 4: matched pair count, 0–8.
- `moves` out 8: completed two-card attempts, saturates at 255.
- `game_done` out 1: all 8 pairs matched.

## Operation
- Card index = row*4 + col. Card i occupies x ∈ [GRID_X+col*(CARD_W+GAP), +CARD_W) and y ∈ [GRID_Y+row*(CARD_H+GAP), +CARD_H), with half-open bounds. A click in a gap or outside the grid misses.
- A click is the rising edge of `left`: `left`=1 while the registered `left_d`=0. A held button produces exactly one click.
- A hit is valid only if the click position is on card i, `face_up[i]`=0 and `matched[i]`=0. Any other click is discarded.
- States:
  - IDLE: all outputs cleared. Moves to FIRST when `start`=1.
  - FIRST: a valid hit sets `face_up[i]` and stores first_idx, then moves to SECOND.
  - SECOND: a valid hit sets `face_up[j]`, stores second_idx, increments `moves` (saturating), then moves to COMPARE.
  - COMPARE (1 cycle), when IDs are equal: set `matched[first]` and `matched[second]`, clear both `face_up` bits, increment `pairs_found`. Go to DONE if the new count is 8, otherwise to FIRST.
  - COMPARE, when IDs differ: load the counter with SHOW_CYCLES−1 and go to SHOW.
  - SHOW: the counter decrements each cycle. At 0, clear both `face_up` bits and go to FIRST. All clicks are discarded.
  - DONE: `game_done`=1 and outputs are frozen.
- `start`=0 in any state forces IDLE on the next edge and clears all state. This is the restart mechanism, including mid-SHOW.
- `card_values` is sampled only in COMPARE. Its bits are don't-care at other times.

## Timing
- Reset value: all outputs 0, state IDLE, `left_d`=0, counter 0.
- Edge k: `left` is sampled 1 with `left_d`=0. Edge k+1: hit_valid and hit_idx are registered. Edge k+2: `face_up` updates. Latency from press to display is 2 cycles.
- The second card is shown at k+2, and COMPARE happens at k+3. Match outputs (`matched`, `pairs_found`, `face_up` cleared) are visible after edge k+3.
- Mismatch: `face_up` clears exactly SHOW_CYCLES+1 edges after COMPARE.
- A click registered in the hit stage during a state transition is evaluated against the state current at edge k+2. No queuing of clicks.
- `game_done` rises on the same edge that sets the last `matched` bits.

## Test plan
- Reset then `start`=1; click at (256,128), the centre of card 0 → after 2 cycles `face_up`=0x0001, `moves`=0.
- With `card_values` having cards 0 and 1 both ID 3: click card 0, then card 1 at (416,128) → `matched`=0x0003, `face_up`=0, `pairs_found`=1, `moves`=1.
- With SHOW_CYCLES=10 and cards 0/5 of differing IDs: click 0, then 5 → `face_up`=0x0021 for 11 cycles after COMPARE, then 0. Clicks during SHOW change nothing.
- Click at (336,128), a gap; click already-up card 0 again; hold `left` high for 100 cycles → exactly one selection recorded, no extra `moves`.
- Mid-SHOW drop `start` for 1 cycle, then reassert → all outputs 0, state FIRST, new clicks accepted.
- Play 8 correct pairs → `pairs_found`=8, `moves`=8, `matched`=0xFFFF, `game_done`=1. Further clicks produce no change.

Source files
------------

// File: rtl/card_pair_controller.sv
// card_pair_controller: turns mouse clicks into card selections on the 4x4 memory board,
// compares each selected pair, and tracks face-up / matched bitmaps plus game completion.

module card_hit #(
  parameter int X0 = 0,
  parameter int Y0 = 0,
  parameter int W  = 128,
  parameter int H  = 128
) (
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic        hit
);
  localparam logic [12:0] XL = 13'(X0);
  localparam logic [12:0] XR = 13'(X0 + W);
  localparam logic [12:0] YT = 13'(Y0);
  localparam logic [12:0] YB = 13'(Y0 + H);

  // half-open box: the pixel at X0+W already belongs to the gap
  assign hit = ({1'b0, x} >= XL) && ({1'b0, x} < XR) &&
               ({1'b0, y} >= YT) && ({1'b0, y} < YB);
endmodule

module card_pair_controller #(
  parameter int GRID_X      = 192,
  parameter int GRID_Y      = 64,
  parameter int CARD_W      = 128,
  parameter int CARD_H      = 128,
  parameter int GAP         = 32,
  parameter int SHOW_CYCLES = 65_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        left,
  input  logic [63:0] card_values,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  output logic [3:0]  pairs_found,
  output logic [7:0]  moves,
  output logic        game_done
);
  localparam int          NUM_CARDS = 16;
  localparam logic [26:0] SHOW_LOAD = 27'(SHOW_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FIRST, SECOND, COMPARE, SHOW, DONE} state_t;

  state_t      state, state_nx;
  logic        left_d;
  logic        click;
  logic [11:0] x_q, y_q;
  logic [2:1]  vld_pipe;
  logic [15:0] on_card;
  logic [3:0]  hit_enc, hit_idx;
  logic        accept;
  logic [3:0]  first_idx, second_idx, first_nx, second_nx;
  logic [3:0]  id_first, id_second;
  logic [15:0] face_up_nx, matched_nx;
  logic [3:0]  pairs_nx;
  logic [7:0]  moves_nx;
  logic [26:0] cnt, cnt_nx;
  logic        expire, expire_nx;

  assign click = left & ~left_d;

  for (genvar i = 0; i < NUM_CARDS; i++) begin : g_card
    card_hit #(
      .X0(GRID_X + (i % 4) * (CARD_W + GAP)),
      .Y0(GRID_Y + (i / 4) * (CARD_H + GAP)),
      .W (CARD_W),
      .H (CARD_H)
    ) u_hit (
      .x  (x_q),
      .y  (y_q),
      .hit(on_card[i])
    );
  end

  // cards never overlap, so at most one bit of on_card is set
  always_comb begin
    hit_enc = '0;
    for (int i = 0; i < NUM_CARDS; i++)
      if (on_card[i]) hit_enc = hit_enc | 4'(i);
  end

  assign accept    = vld_pipe[2] && !face_up[hit_idx] && !matched[hit_idx];
  assign id_first  = card_values[{first_idx, 2'b00} +: 4];
  assign id_second = card_values[{second_idx, 2'b00} +: 4];
  assign game_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      left_d      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      vld_pipe    <= '0;
      hit_idx     <= '0;
      face_up     <= '0;
      matched     <= '0;
      pairs_found <= '0;
      moves       <= '0;
      first_idx   <= '0;
      second_idx  <= '0;
      cnt         <= '0;
      expire      <= 1'b0;
    end else begin
      left_d      <= left;
      x_q         <= xpos;
      y_q         <= ypos;
      vld_pipe[1] <= start & click;
      vld_pipe[2] <= start & vld_pipe[1] & (|on_card);
      hit_idx     <= hit_enc;
      state       <= state_nx;
      face_up     <= face_up_nx;
      matched     <= matched_nx;
      pairs_found <= pairs_nx;
      moves       <= moves_nx;
      first_idx   <= first_nx;
      second_idx  <= second_nx;
      cnt         <= cnt_nx;
      expire      <= expire_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    face_up_nx = face_up;
    matched_nx = matched;
    pairs_nx   = pairs_found;
    moves_nx   = moves;
    first_nx   = first_idx;
    second_nx  = second_idx;
    cnt_nx     = cnt;
    expire_nx  = expire;
    if (!start || state == IDLE) begin
      face_up_nx = '0;
      matched_nx = '0;
      pairs_nx   = '0;
      moves_nx   = '0;
      first_nx   = '0;
      second_nx  = '0;
      cnt_nx     = '0;
      expire_nx  = 1'b0;
      state_nx   = start ? FIRST : IDLE;
    end else begin
      case (state)
        FIRST: if (accept) begin
          face_up_nx[hit_idx] = 1'b1;
          first_nx            = hit_idx;
          state_nx            = SECOND;
        end
        SECOND: if (accept) begin
          face_up_nx[hit_idx] = 1'b1;
          second_nx           = hit_idx;
          if (moves != 8'hFF) moves_nx = moves + 1'b1;
          state_nx            = COMPARE;
        end
        COMPARE: if (id_first == id_second) begin
          matched_nx[first_idx]  = 1'b1;
          matched_nx[second_idx] = 1'b1;
          face_up_nx[first_idx]  = 1'b0;
          face_up_nx[second_idx] = 1'b0;
          pairs_nx               = pairs_found + 1'b1;
          state_nx               = (pairs_found == 4'd7) ? DONE : FIRST;
        end else begin
          cnt_nx   = SHOW_LOAD;
          state_nx = SHOW;
        end
        // one extra cycle after reaching zero keeps the pair up SHOW_CYCLES+1 edges past COMPARE
        SHOW: if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (!expire) begin
          expire_nx = 1'b1;
        end else begin
          face_up_nx[first_idx]  = 1'b0;
          face_up_nx[second_idx] = 1'b0;
          expire_nx              = 1'b0;
          state_nx               = FIRST;
        end
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_card_pair_controller.sv
// Bench for card_pair_controller: directed timing scenarios plus randomized games checked
// against a click-level model of the board rules.

module tb_card_pair_controller;
  localparam int SHOW = 10;

  logic        clk = 1'b0;
  logic        rst, start, left;
  logic [11:0] xpos, ypos;
  logic [63:0] card_values;
  logic [15:0] face_up, matched;
  logic [3:0]  pairs_found;
  logic [7:0]  moves;
  logic        game_done;

  int n_chk = 0;
  int n_bad = 0;

  int       ids [16];
  bit [15:0] m_face, m_match;
  int       m_moves, m_pairs, m_first;
  bit       m_hf, m_done;

  always #5 clk = ~clk;

  card_pair_controller #(.SHOW_CYCLES(SHOW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .xpos       (xpos),
    .ypos       (ypos),
    .left       (left),
    .card_values(card_values),
    .face_up    (face_up),
    .matched    (matched),
    .pairs_found(pairs_found),
    .moves      (moves),
    .game_done  (game_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] f, input logic [15:0] m,
                         input int p, input int mv, input bit d);
    chk({tag, ".face"},  32'(face_up),     32'(f));
    chk({tag, ".match"}, 32'(matched),     32'(m));
    chk({tag, ".pairs"}, 32'(pairs_found), 32'(p));
    chk({tag, ".moves"}, 32'(moves),       32'(mv));
    chk({tag, ".done"},  32'(game_done),   32'(d));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int cx(input int i);
    return 192 + (i % 4) * 160 + 64;
  endfunction

  function automatic int cy(input int i);
    return 64 + (i / 4) * 160 + 64;
  endfunction

  // board geometry from plain arithmetic: pitch 160, card 128, 4x4
  function automatic int card_of(input int x, input int y);
    int dx, dy;
    if (x < 192 || y < 64) return -1;
    dx = x - 192;
    dy = y - 64;
    if (dx / 160 > 3 || dy / 160 > 3 || dx % 160 >= 128 || dy % 160 >= 128) return -1;
    return (dy / 160) * 4 + dx / 160;
  endfunction

  task automatic load_ids;
    for (int i = 0; i < 16; i++) card_values[4*i +: 4] = 4'(ids[i]);
  endtask

  task automatic press(input int x, input int y);
    xpos = 12'(x);
    ypos = 12'(y);
    left = 1'b1;
    tick;
    left = 1'b0;
  endtask

  task automatic click_card(input int i);
    press(cx(i), cy(i));
    repeat (3) tick;
  endtask

  task automatic restart;
    start = 1'b0;
    tick;
    start = 1'b1;
    tick;
  endtask

  task automatic model_reset;
    m_face = '0; m_match = '0; m_moves = 0; m_pairs = 0; m_first = 0; m_hf = 0; m_done = 0;
  endtask

  task automatic model_click(input int x, input int y, output bit mis);
    int c;
    c   = card_of(x, y);
    mis = 1'b0;
    if (m_done || c < 0) return;
    if (m_face[c] || m_match[c]) return;
    if (!m_hf) begin
      m_face[c] = 1'b1;
      m_first   = c;
      m_hf      = 1'b1;
    end else begin
      if (m_moves < 255) m_moves++;
      m_hf   = 1'b0;
      m_face = '0;
      if (ids[c] == ids[m_first]) begin
        m_match[c]       = 1'b1;
        m_match[m_first] = 1'b1;
        m_pairs++;
        if (m_pairs == 8) m_done = 1'b1;
      end else begin
        mis = 1'b1;
      end
    end
  endtask

  task automatic rand_game;
    int x, y, kind, hold, extra, s, k, t;
    bit mis;
    for (int i = 0; i < 16; i++) ids[i] = i / 2;
    for (int i = 15; i > 0; i--) begin
      k = int'($urandom_range(i, 0));
      t = ids[i]; ids[i] = ids[k]; ids[k] = t;
    end
    load_ids;
    restart;
    model_reset;
    extra = 0;
    for (int n = 0; n < 90 && extra < 3; n++) begin
      kind = int'($urandom_range(9, 0));
      if (kind == 0) begin
        x = 192 + int'($urandom_range(2, 0)) * 160 + 128 + int'($urandom_range(31, 0));
        y = cy(int'($urandom_range(15, 0)));
      end else if (kind == 1) begin
        x = int'($urandom_range(191, 0));
        y = int'($urandom_range(700, 0));
      end else if (kind <= 5) begin
        k = int'($urandom_range(15, 0));
        x = 192 + (k % 4) * 160 + int'($urandom_range(127, 0));
        y = 64 + (k / 4) * 160 + int'($urandom_range(127, 0));
      end else begin
        s = int'($urandom_range(15, 0));
        k = s;
        if (m_hf) begin
          for (int j = 0; j < 16; j++)
            if (j != m_first && ids[j] == ids[m_first]) k = j;
        end else begin
          for (int j = 15; j >= 0; j--)
            if (!m_match[(s + j) % 16]) k = (s + j) % 16;
        end
        x = cx(k);
        y = cy(k);
      end
      hold = int'($urandom_range(3, 1));
      xpos = 12'(x);
      ypos = 12'(y);
      left = 1'b1;
      repeat (hold) tick;
      left = 1'b0;
      repeat (4) tick;
      model_click(x, y, mis);
      if (mis) repeat (SHOW + 4) tick;
      chk_all("rand", m_face, m_match, m_pairs, m_moves, m_done);
      if (m_done) extra++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; left = 1'b0; xpos = '0; ypos = '0;
    ids = '{3, 3, 0, 0, 1, 1, 2, 2, 4, 4, 5, 5, 6, 6, 7, 7};
    load_ids;
    repeat (2) tick;
    chk_all("reset", 16'h0, 16'h0, 0, 0, 1'b0);
    rst = 1'b0;
    start = 1'b1;
    tick;

    // press-to-display latency on card 0
    press(256, 128);
    chk("lat.k", 32'(face_up), 32'h0);
    tick;
    chk("lat.k1", 32'(face_up), 32'h0);
    tick;
    chk("lat.k2", 32'(face_up), 32'h1);
    chk("lat.moves", 32'(moves), 32'h0);
    tick;

    // matching pair 0/1
    press(416, 128);
    repeat (2) tick;
    chk("match.up", 32'(face_up), 32'h3);
    tick;
    chk_all("match", 16'h0, 16'h3, 1, 1, 1'b0);

    // mismatch 0/5 with exact hide timing, click during SHOW ignored
    restart;
    chk_all("restart", 16'h0, 16'h0, 0, 0, 1'b0);
    click_card(0);
    press(cx(5), cy(5));
    repeat (2) tick;
    chk("mis.up", 32'(face_up), 32'h21);
    tick;
    chk("mis.cmp", 32'(face_up), 32'h21);
    for (int j = 1; j <= SHOW; j++) begin
      tick;
      chk("mis.show", 32'(face_up), 32'h21);
      if (j == 2) begin
        xpos = 12'(cx(2)); ypos = 12'(cy(2)); left = 1'b1;
      end
      if (j == 4) left = 1'b0;
    end
    tick;
    chk_all("mis.hide", 16'h0, 16'h0, 0, 1, 1'b0);

    // gap, repeat click, held button
    restart;
    press(336, 128);
    repeat (3) tick;
    chk("gap", 32'(face_up), 32'h0);
    click_card(0);
    chk("sel0", 32'(face_up), 32'h1);
    click_card(0);
    chk_all("dup", 16'h1, 16'h0, 0, 0, 1'b0);
    xpos = 12'(cx(2)); ypos = 12'(cy(2)); left = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (i == 2) begin
        chk("hold.up", 32'(face_up), 32'h5);
        chk("hold.mv", 32'(moves), 32'h1);
      end
    end
    left = 1'b0;
    repeat (3) tick;
    chk_all("hold", 16'h0, 16'h0, 0, 1, 1'b0);

    // drop start mid-SHOW, then resume
    restart;
    click_card(0);
    press(cx(5), cy(5));
    repeat (5) tick;
    start = 1'b0;
    tick;
    chk_all("drop", 16'h0, 16'h0, 0, 0, 1'b0);
    start = 1'b1;
    tick;
    click_card(3);
    chk_all("resume", 16'h8, 16'h0, 0, 0, 1'b0);

    // full game in order, then frozen
    restart;
    for (int p = 0; p < 8; p++) begin
      click_card(2 * p);
      click_card(2 * p + 1);
    end
    chk_all("full", 16'h0, 16'hFFFF, 8, 8, 1'b1);
    click_card(0);
    click_card(5);
    chk_all("frozen", 16'h0, 16'hFFFF, 8, 8, 1'b1);

    for (int g = 0; g < 3; g++) rand_game;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
